lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
Load/store unit directly downstream of the ALU in the rv32i execute path. It consumes the ALU sum (rs1 + imm) as the effective address, runs one data-memory transaction over a valid/ready bus, and returns aligned, extended load data to writeback. It is a single-outstanding, multi-cycle FSM. The pipeline stalls on o_req_ready low.

Parameters:
TIMEOUT_CYCLES, 16, bus watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined; legal range 1..255.

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  reset, asynchronous, active-high
i_req_valid  input  1  load/store request from execute
o_req_ready  output  1  high only in IDLE
i_addr  input  32  effective address (ALU result)
i_wdata  input  32  store data (rs2)
i_funct3  input  3  RV32I load/store width/sign field
i_is_store  input  1  1 = store, 0 = load
o_resp_valid  output  1  one-cycle completion pulse
o_rdata  output  32  extended load data; 0 for stores and errors
o_err  output  1  qualified by o_resp_valid: misaligned, illegal funct3, or timeout
o_mem_valid  output  1  bus request
i_mem_ready  input  1  bus accept; read data valid in the same cycle
o_mem_addr  output  32  word address, {i_addr[31:2],2'b00}
o_mem_we  output  1  write enable
o_mem_wstrb  output  4  byte lanes; 0000 for loads
o_mem_wdata  output  32  lane-replicated store data
i_mem_rdata  input  32  read word

Behaviour:
- Reset (async, immediate): state IDLE, o_mem_valid=0, o_resp_valid=0, o_err=0, o_rdata=0, o_mem_addr/wdata/wstrb/we=0. An in-flight bus request is dropped at once and no response is issued.
- States: IDLE, BUS, DONE.
- IDLE: o_req_ready=1. If i_req_valid=1, latch addr, wdata, funct3, is_store and decode:
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - Illegal or misaligned -> DONE with err=1; no bus cycle.
  - Otherwise -> BUS.
- BUS: o_mem_valid=1. Addr, we, wstrb and wdata stay stable until i_mem_ready=1.
  - On ready: loads capture rdata, then -> DONE.
  - Each ready=0 cycle extends BUS by one cycle.
- DONE: o_resp_valid=1 for exactly one cycle, with o_rdata/o_err valid, then -> IDLE. o_req_ready=0.
- Latency: request accepted at edge T -> o_mem_valid high in cycle T+1. With zero wait states, o_resp_valid is high in cycle T+2. Error path: o_resp_valid in cycle T+1.
- Back-to-back: a new request can be accepted the cycle after DONE. Throughput is at most 1 per 3 cycles.
- Store lanes, with o = addr[1:0]:
  - SB: wdata={4{b}}, wstrb=0001<<o.
  - SH: wdata={2{h}}, wstrb=0011 (o=0) or 1100 (o=2).
  - SW: wdata=word, wstrb=1111.
- Load extract: byte = rdata[8*o+:8]; half = rdata[16*o[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- o_rdata holds its value outside DONE; downstream must sample only on o_resp_valid.
- i_req_valid is ignored outside IDLE. There is no request buffering.

Optional Feature:
LSU_TIMEOUT_EN.
- Defined: an 8-bit watchdog counter clears on BUS entry and increments each BUS cycle with i_mem_ready=0.
  - When it reaches TIMEOUT_CYCLES: drop o_mem_valid, go to DONE with o_err=1, o_rdata=0.
  - If ready arrives in the same cycle the limit is reached, the transfer wins and o_err=0.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- LB at addr 0x1003, rdata 0x80FF_0000 -> wstrb 0000, o_rdata 0xFFFF_FF80, err 0; resp at T+2 with zero wait.
- LHU at 0x2002, rdata 0xBEEF_1234 -> o_rdata 0x0000_BEEF.
- SB at 0x3001, wdata 0x0000_00A5, ready after 3 wait cycles -> mem_addr 0x3000, wstrb 0010, wdata 0xA5A5_A5A5 held stable; resp at T+5, o_rdata 0.
- LW at 0x4002 -> no o_mem_valid, resp at T+1 with err 1. funct3=011 load -> same result.
- i_rst pulsed mid-BUS -> o_mem_valid falls before the next edge, no o_resp_valid, o_req_ready=1 after release.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready held low -> mem_valid drops after 4 BUS cycles, resp with err 1. Without the macro, mem_valid stays high for 100 cycles.

Source files
------------

// File: rtl/lsu_stage_if.sv
// Request/response and data-memory bus bundle for lsu_stage.
// master = execute/writeback side plus memory model; slave = the LSU itself.
interface lsu_stage_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [2:0]  i_funct3;
  logic        i_is_store;
  logic        o_resp_valid;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  modport master (
    output i_req_valid, i_addr, i_wdata, i_funct3, i_is_store, i_mem_ready, i_mem_rdata,
    input  o_req_ready, o_resp_valid, o_rdata, o_err, o_mem_valid, o_mem_addr, o_mem_we,
           o_mem_wstrb, o_mem_wdata
  );

  modport slave (
    input  i_req_valid, i_addr, i_wdata, i_funct3, i_is_store, i_mem_ready, i_mem_rdata,
    output o_req_ready, o_resp_valid, o_rdata, o_err, o_mem_valid, o_mem_addr, o_mem_we,
           o_mem_wstrb, o_mem_wdata
  );
endinterface

// File: rtl/lsu_stage.sv
// Single-outstanding rv32i load/store unit: IDLE -> BUS -> DONE over a valid/ready bus.
// Define LSU_TIMEOUT_EN to add a bus watchdog of TIMEOUT_CYCLES stalled cycles.
module lsu_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic        i_clk,
  input logic        i_rst,
  lsu_stage_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  // Request decode straight off the execute inputs; only consumed in IDLE.
  logic        req_legal;
  logic        req_misaligned;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;

  always_comb begin
    if (bus.i_is_store) req_legal = bus.i_funct3 inside {3'b000, 3'b001, 3'b010};
    else                req_legal = bus.i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_misaligned = (bus.i_funct3[1:0] == 2'b01 && bus.i_addr[0]) ||
                     (bus.i_funct3[1:0] == 2'b10 && bus.i_addr[1:0] != 2'b00);
    case (bus.i_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{bus.i_wdata[7:0]}};
        lane_strb  = 4'b0001 << bus.i_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{bus.i_wdata[15:0]}};
        lane_strb  = bus.i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = bus.i_wdata;
        lane_strb  = 4'b1111;
      end
    endcase
  end

  // Load extraction from the returned word using the latched offset.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = bus.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = bus.i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.i_mem_rdata;
    endcase
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid) begin
          addr_d   = bus.i_addr;
          funct3_d = bus.i_funct3;
          we_d     = bus.i_is_store;
          wdata_d  = lane_wdata;
          if (!req_legal || req_misaligned) begin
            wstrb_d = 4'b0000;
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_DONE;
          end else begin
            wstrb_d = bus.i_is_store ? lane_strb : 4'b0000;
            state_d = S_BUS;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
          end
        end
      end
      S_BUS: begin
        if (bus.i_mem_ready) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        // A ready arriving on the limit cycle takes the branch above and wins.
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers take non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.o_req_ready  = (state_q == S_IDLE);
  assign bus.o_mem_valid  = (state_q == S_BUS);
  assign bus.o_resp_valid = (state_q == S_DONE);
  assign bus.o_rdata      = rdata_q;
  assign bus.o_err        = err_q;
  assign bus.o_mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.o_mem_we     = we_q;
  assign bus.o_mem_wstrb  = wstrb_q;
  assign bus.o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed vector table, reset/watchdog sequences,
// and randomized transactions against a byte-level reference model.
module tb_lsu_stage;

  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_stage_if bus_if ();
  lsu_stage #(.TIMEOUT_CYCLES(TO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus_if));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        bus;
    int          nbus;
    logic [31:0] maddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
    logic        stable;
    logic        done;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic        resp_after;
    logic        ready_after;
  } obs_t;

  typedef struct {
    logic        bus;
    int          nbus;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        e_bus;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    int          e_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and play the memory side: ready after `waits` stalled BUS cycles.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits,
                         output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    @(negedge clk);
    bus_if.i_req_valid = 1'b1;
    bus_if.i_is_store  = st;
    bus_if.i_funct3    = f3;
    bus_if.i_addr      = a;
    bus_if.i_wdata     = wd;
    bus_if.i_mem_ready = 1'b0;
    @(posedge clk);
    #1;
    bus_if.i_req_valid = 1'b0;
    bus_if.i_addr      = $urandom;
    bus_if.i_wdata     = $urandom;
    bus_if.i_funct3    = 3'($urandom);
    bus_if.i_is_store  = 1'($urandom);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus_if.o_resp_valid) begin
        o.lat   = k;
        o.rdata = bus_if.o_rdata;
        o.err   = bus_if.o_err;
        o.done  = 1'b1;
        break;
      end
      if (bus_if.o_mem_valid) begin
        if (!o.bus) begin
          o.maddr = bus_if.o_mem_addr;
          o.wstrb = bus_if.o_mem_wstrb;
          o.wdata = bus_if.o_mem_wdata;
          o.we    = bus_if.o_mem_we;
        end else if (o.maddr !== bus_if.o_mem_addr || o.wstrb !== bus_if.o_mem_wstrb ||
                     o.wdata !== bus_if.o_mem_wdata || o.we !== bus_if.o_mem_we) begin
          o.stable = 1'b0;
        end
        o.bus = 1'b1;
        o.nbus++;
        bus_if.i_mem_ready = (o.nbus == waits + 1);
        bus_if.i_mem_rdata = (o.nbus == waits + 1) ? rd : $urandom;
      end else begin
        bus_if.i_mem_ready = 1'b0;
      end
    end
    bus_if.i_mem_ready = 1'b0;
    bus_if.i_mem_rdata = $urandom;
    @(negedge clk);
    o.resp_after  = bus_if.o_resp_valid;
    o.ready_after = bus_if.o_req_ready;
  endtask

  // Reference model: byte-level arithmetic straight from the ISA rules.
  function automatic exp_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int waits);
    exp_t e;
    bit legal;
    int size;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    e = '{default: '0};
    case (f3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !st;
      default:          legal = 1'b0;
    endcase
    size = 1 << f3[1:0];
    off  = int'(a % 4);
    if (!legal || (a % size) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    e.bus = 1'b1;
    if (st) begin
      e.wstrb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
      v = (rd >> (8 * off)) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end
    if (TO_EN && waits >= TO) begin
      e.err   = 1'b1;
      e.rdata = 32'd0;
      e.nbus  = TO;
      e.lat   = TO + 1;
    end else begin
      e.nbus = waits + 1;
      e.lat  = waits + 2;
    end
    return e;
  endfunction

  task automatic compare(input string tag, input logic st, input logic [31:0] a,
                         input obs_t o, input exp_t e);
    check({tag, "_done"}, 32'(o.done), 32'd1);
    check({tag, "_lat"}, o.lat, e.lat);
    check({tag, "_err"}, 32'(o.err), 32'(e.err));
    check({tag, "_rdata"}, o.rdata, e.rdata);
    check({tag, "_bus"}, 32'(o.bus), 32'(e.bus));
    check({tag, "_pulse"}, {o.resp_after, o.ready_after}, 32'b01);
    if (e.bus) begin
      check({tag, "_nbus"}, o.nbus, e.nbus);
      check({tag, "_maddr"}, o.maddr, a & 32'hFFFF_FFFC);
      check({tag, "_we"}, 32'(o.we), 32'(st));
      check({tag, "_wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
      check({tag, "_stable"}, 32'(o.stable), 32'd1);
      if (st) check({tag, "_wdata"}, o.wdata, e.wdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t  vt[14];
    obs_t  o;
    exp_t  e;
    logic  seen;

    bus_if.i_req_valid = 1'b0;
    bus_if.i_addr      = '0;
    bus_if.i_wdata     = '0;
    bus_if.i_funct3    = '0;
    bus_if.i_is_store  = 1'b0;
    bus_if.i_mem_ready = 1'b0;
    bus_if.i_mem_rdata = '0;

    //                st  f3      addr          wdata         rdata        w  bus err e_rdata       strb     e_wdata       lat
    vt[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 1'b1, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,        2};
    vt[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1'b1, 1'b0, 32'h0000_BEEF, 4'b0000, 32'h0,        2};
    vt[2]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0,        3, 1'b1, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 5};
    vt[3]  = '{1'b0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        1};
    vt[4]  = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,         0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        1};
    vt[5]  = '{1'b1, 3'b001, 32'h0000_5002, 32'h1234_BEEF, 32'h0,        1, 1'b1, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 3};
    vt[6]  = '{1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 2};
    vt[7]  = '{1'b0, 3'b001, 32'h0000_7000, 32'h0,        32'h1234_8001, 0, 1'b1, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0,        2};
    vt[8]  = '{1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h1234_8001, 0, 1'b1, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        2};
    vt[9]  = '{1'b1, 3'b100, 32'h0000_7000, 32'h1111_1111, 32'h0,        0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        1};
    vt[10] = '{1'b1, 3'b001, 32'h0000_5001, 32'h2222_2222, 32'h0,        0, 1'b0, 1'b1, 32'h0,         4'b0000, 32'h0,        1};
    vt[11] = '{1'b0, 3'b010, 32'h0000_8000, 32'h0,        32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'hCAFE_F00D, 4'b0000, 32'h0,        4};
    vt[12] = '{1'b0, 3'b000, 32'h0000_8002, 32'h0,        32'h007F_0000, 0, 1'b1, 1'b0, 32'h0000_007F, 4'b0000, 32'h0,        2};
    vt[13] = '{1'b1, 3'b000, 32'h0000_9003, 32'hFFFF_FF3C, 32'h0,        0, 1'b1, 1'b0, 32'h0,         4'b1000, 32'h3C3C_3C3C, 2};

    // Reset state.
    #3;
    check("rst_req_ready", 32'(bus_if.o_req_ready), 32'd1);
    check("rst_valids", {bus_if.o_mem_valid, bus_if.o_resp_valid, bus_if.o_err, bus_if.o_mem_we}, 32'd0);
    check("rst_rdata", bus_if.o_rdata, 32'd0);
    check("rst_mem_addr", bus_if.o_mem_addr, 32'd0);
    check("rst_mem_wdata", bus_if.o_mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus_if.o_mem_wstrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    foreach (vt[i]) begin
      run_txn(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].waits, o);
      e = '{bus: vt[i].e_bus, nbus: vt[i].waits + 1, err: vt[i].e_err, rdata: vt[i].e_rdata,
            wstrb: vt[i].e_wstrb, wdata: vt[i].e_wdata, lat: vt[i].e_lat};
      compare($sformatf("vec%0d", i), vt[i].st, vt[i].addr, o, e);
    end

    // Reset pulsed in the middle of a stalled bus cycle.
    @(negedge clk);
    bus_if.i_req_valid = 1'b1;
    bus_if.i_is_store  = 1'b0;
    bus_if.i_funct3    = 3'b010;
    bus_if.i_addr      = 32'h0000_9000;
    bus_if.i_mem_ready = 1'b0;
    @(posedge clk);
    #1;
    bus_if.i_req_valid = 1'b0;
    @(negedge clk);
    check("midrst_mem_valid_before", 32'(bus_if.o_mem_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_mem_valid_async", 32'(bus_if.o_mem_valid), 32'd0);
    check("midrst_mem_addr", bus_if.o_mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus_if.o_resp_valid || bus_if.o_mem_valid) seen = 1'b1;
    end
    check("midrst_no_resp", 32'(seen), 32'd0);
    check("midrst_req_ready", 32'(bus_if.o_req_ready), 32'd1);

    // Long stall: watchdog fires after TO cycles, or without it the bus waits 100 cycles.
    run_txn(1'b0, 3'b010, 32'h0000_A000, 32'h0, 32'h1357_9BDF, 100, o);
`ifdef LSU_TIMEOUT_EN
    check("stall_nbus", o.nbus, TO);
    check("stall_lat", o.lat, TO + 1);
    check("stall_err", 32'(o.err), 32'd1);
    check("stall_rdata", o.rdata, 32'd0);
    // Ready on the limit cycle: the transfer wins.
    run_txn(1'b0, 3'b010, 32'h0000_A004, 32'h0, 32'h2468_ACE0, TO - 1, o);
    check("limit_err", 32'(o.err), 32'd0);
    check("limit_rdata", o.rdata, 32'h2468_ACE0);
    check("limit_lat", o.lat, TO + 1);
`else
    check("stall_nbus", o.nbus, 101);
    check("stall_lat", o.lat, 102);
    check("stall_err", 32'(o.err), 32'd0);
    check("stall_rdata", o.rdata, 32'h1357_9BDF);
`endif

    // Randomized transactions against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          w;
      st = 1'($urandom);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      wd = $urandom;
      rd = $urandom;
      w  = $urandom_range(0, 6);
      run_txn(st, f3, a, wd, rd, w, o);
      e = model(st, f3, a, wd, rd, w);
      compare($sformatf("rnd%0d", n), st, a, o, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
